sram_req_arbiter: RTL and testbench

- Upstream stage of the SRAM controller: accepts byte read/write requests from two independent requesters.
- Arbitrates round-robin and issues one command at a time on the controller's command interface.
- Returns completion, and read data where applicable, to the owning requester.
- Guards each access with a timeout so that a stalled controller cannot hang either requester.

---
 rtl/sram_arb_pkg.sv | 29 ++
 rtl/sram_req_arbiter_rr_pick2.sv | 42 ++++
 rtl/sram_req_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_sram_req_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// -----------------------------------------------------------------------------
// sram_arb_pkg
// Shared definitions for the SRAM request arbiter: FSM state encoding,
// requester port indices and default parameter values.
// -----------------------------------------------------------------------------
package sram_arb_pkg;

    // Arbiter FSM state encoding (IDLE = 1'b0, WAIT = 1'b1)
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } arb_state_t;

    // Requester port indices
    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    // Default configuration
    localparam int DEFAULT_ADDR_W  = 16;
    localparam int DEFAULT_DATA_W  = 8;
    localparam int DEFAULT_TIMEOUT = 16;
    localparam int DEFAULT_CNT_W   = 8;

    // Index of the port that did not win; used to advance the round-robin pointer
    function automatic logic other_port(input logic port);
        return ~port;
    endfunction

endpackage

// File: rtl/sram_req_arbiter_rr_pick2.sv
// -----------------------------------------------------------------------------
// rr_pick2
// Combinational two-way round-robin selector.
//   req[1:0] : request vector, bit N = port N requesting
//   ptr      : port that wins when both request
//   valid    : at least one request present
//   winner   : index of the selected port (PORT0 when valid = 0)
// -----------------------------------------------------------------------------
module rr_pick2
    import sram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ptr,
    output logic       valid,
    output logic       winner
);

    // Select a lone requester directly; on contention defer to the pointer
    always_comb begin
        valid  = 1'b0;
        winner = PORT0;
        case (req)
            2'b01: begin
                valid  = 1'b1;
                winner = PORT0;
            end
            2'b10: begin
                valid  = 1'b1;
                winner = PORT1;
            end
            2'b11: begin
                valid  = 1'b1;
                winner = ptr;
            end
            default: begin
                valid  = 1'b0;
                winner = PORT0;
            end
        endcase
    end

endmodule

// File: rtl/sram_req_arbiter.sv
// -----------------------------------------------------------------------------
// sram_req_arbiter
// Upstream stage of the SRAM controller. Accepts byte read/write commands from
// two requesters, arbitrates round-robin, issues one command at a time to the
// controller and routes completion (and read data) back to the owning port.
// A per-access timeout forces an error completion if the controller stalls.
//
// Ports:
//   clk, reset                 clock (rising edge), async active-high reset
//   pN_req/rw/addr/wdata       requester N command (held until pN_gnt)
//   pN_gnt                     1-cycle pulse: command captured
//   pN_ack / pN_err            1-cycle completion pulse / timed-out qualifier
//   pN_rdata                   read data, valid with pN_ack on reads
//   ctl_req                    1-cycle command pulse to the controller
//   ctl_rw/addr/wdata          latched command, stable until the next grant
//   ctl_done / ctl_rdata       controller completion pulse and read data
// -----------------------------------------------------------------------------
module sram_req_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CNT_W   = DEFAULT_CNT_W
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              p0_req,
    input  logic              p0_rw,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_ack,
    output logic              p0_err,
    output logic [DATA_W-1:0] p0_rdata,

    input  logic              p1_req,
    input  logic              p1_rw,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_ack,
    output logic              p1_err,
    output logic [DATA_W-1:0] p1_rdata,

    output logic              ctl_req,
    output logic              ctl_rw,
    output logic [ADDR_W-1:0] ctl_addr,
    output logic [DATA_W-1:0] ctl_wdata,
    input  logic              ctl_done,
    input  logic [DATA_W-1:0] ctl_rdata
);

    // Counter value seen on the last permitted WAIT edge
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_t        state_r;
    logic              rr_ptr_r;
    logic              owner_r;
    logic [CNT_W-1:0]  cnt_r;

    logic              pick_valid_s;
    logic              pick_winner_s;
    logic              sel_rw_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;

    logic              finish_s;
    logic              finish_err_s;
    logic              rdata_load_s;
    logic [DATA_W-1:0] rdata_next_s;

    rr_pick2 u_pick (
        .req    ({p1_req, p0_req}),
        .ptr    (rr_ptr_r),
        .valid  (pick_valid_s),
        .winner (pick_winner_s)
    );

    // Route the winning requester's command towards the latch
    always_comb begin
        if (pick_winner_s == PORT1) begin
            sel_rw_s    = p1_rw;
            sel_addr_s  = p1_addr;
            sel_wdata_s = p1_wdata;
        end else begin
            sel_rw_s    = p0_rw;
            sel_addr_s  = p0_addr;
            sel_wdata_s = p0_wdata;
        end
    end

    // Completion decode: a controller done always beats the timeout, even on
    // the final cycle, so a late but real response is never reported as error
    always_comb begin
        finish_s     = 1'b0;
        finish_err_s = 1'b0;
        rdata_load_s = 1'b0;
        rdata_next_s = '0;
        if (state_r == ST_WAIT) begin
            if (ctl_done) begin
                finish_s     = 1'b1;
                finish_err_s = 1'b0;
                rdata_load_s = ctl_rw;
                rdata_next_s = ctl_rdata;
            end else if (cnt_r == TIMEOUT_LAST) begin
                finish_s     = 1'b1;
                finish_err_s = 1'b1;
                rdata_load_s = 1'b1;
                rdata_next_s = '0;
            end else begin
                finish_s     = 1'b0;
                finish_err_s = 1'b0;
                rdata_load_s = 1'b0;
                rdata_next_s = '0;
            end
        end else begin
            finish_s     = 1'b0;
            finish_err_s = 1'b0;
            rdata_load_s = 1'b0;
            rdata_next_s = '0;
        end
    end

    // Arbiter FSM with all registered outputs; pulses default low every cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            rr_ptr_r  <= PORT0;
            owner_r   <= PORT0;
            cnt_r     <= '0;
            p0_gnt    <= 1'b0;
            p0_ack    <= 1'b0;
            p0_err    <= 1'b0;
            p0_rdata  <= '0;
            p1_gnt    <= 1'b0;
            p1_ack    <= 1'b0;
            p1_err    <= 1'b0;
            p1_rdata  <= '0;
            ctl_req   <= 1'b0;
            ctl_rw    <= 1'b1;
            ctl_addr  <= '0;
            ctl_wdata <= '0;
        end else begin
            p0_gnt  <= 1'b0;
            p1_gnt  <= 1'b0;
            p0_ack  <= 1'b0;
            p1_ack  <= 1'b0;
            p0_err  <= 1'b0;
            p1_err  <= 1'b0;
            ctl_req <= 1'b0;

            case (state_r)
                ST_IDLE: begin
                    // ctl_done arriving here is stray and deliberately ignored
                    if (pick_valid_s) begin
                        ctl_rw    <= sel_rw_s;
                        ctl_addr  <= sel_addr_s;
                        ctl_wdata <= sel_wdata_s;
                        ctl_req   <= 1'b1;
                        owner_r   <= pick_winner_s;
                        rr_ptr_r  <= other_port(pick_winner_s);
                        cnt_r     <= '0;
                        state_r   <= ST_WAIT;
                        if (pick_winner_s == PORT1) begin
                            p1_gnt <= 1'b1;
                        end else begin
                            p0_gnt <= 1'b1;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end

                ST_WAIT: begin
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (finish_s) begin
                        state_r <= ST_IDLE;
                        if (owner_r == PORT1) begin
                            p1_ack <= 1'b1;
                            p1_err <= finish_err_s;
                            if (rdata_load_s) begin
                                p1_rdata <= rdata_next_s;
                            end else begin
                                p1_rdata <= p1_rdata;
                            end
                        end else begin
                            p0_ack <= 1'b1;
                            p0_err <= finish_err_s;
                            if (rdata_load_s) begin
                                p0_rdata <= rdata_next_s;
                            end else begin
                                p0_rdata <= p0_rdata;
                            end
                        end
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end

                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_req_arbiter
// Self-checking bench: directed scenarios followed by randomized traffic, all
// compared against a transaction-level reference model (per-port command
// queues, a fairness pointer and an expected completion deadline per access).
// -----------------------------------------------------------------------------
module tb_sram_req_arbiter;

    localparam int TMO   = 16;
    localparam int NEVER = 100000;

    logic        clk;
    logic        reset;
    logic        p0_req, p0_rw, p1_req, p1_rw;
    logic [15:0] p0_addr, p1_addr;
    logic [7:0]  p0_wdata, p1_wdata;
    logic        p0_gnt, p0_ack, p0_err, p1_gnt, p1_ack, p1_err;
    logic [7:0]  p0_rdata, p1_rdata;
    logic        ctl_req, ctl_rw, ctl_done;
    logic [15:0] ctl_addr;
    logic [7:0]  ctl_wdata, ctl_rdata;

    sram_req_arbiter #(.ADDR_W(16), .DATA_W(8), .TIMEOUT(TMO), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_rw(p0_rw), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_rw(p1_rw), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
        .ctl_req(ctl_req), .ctl_rw(ctl_rw), .ctl_addr(ctl_addr), .ctl_wdata(ctl_wdata),
        .ctl_done(ctl_done), .ctl_rdata(ctl_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Requester model: one pending command per port, held until granted
    bit          pend_v  [2];
    bit          pend_rw [2];
    logic [15:0] pend_addr[2];
    logic [7:0]  pend_wd [2];

    // Access model
    int          edge_n;
    bit          busy_m;
    int          owner_m, ptr_m, grant_edge, done_edge;
    bit          c_rw;
    logic [15:0] c_addr;
    logic [7:0]  c_wdata;
    logic [7:0]  rdata_m[2];

    // Expected pulses for the edge just taken
    bit e_gnt[2], e_ack[2], e_err[2], e_creq;

    // Stimulus knobs
    int gen_pct, stray_pct, forced_d, rdata_fix;
    int dut_log[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h exp=%0h at edge %0d", tag, got, exp, edge_n);
        end
    endtask

    task automatic model_reset();
        busy_m = 1'b0; ptr_m = 0; owner_m = 0; grant_edge = 0; done_edge = -1;
        c_rw = 1'b1; c_addr = '0; c_wdata = '0;
        rdata_m[0] = '0; rdata_m[1] = '0;
        for (int p = 0; p < 2; p++) begin
            e_gnt[p] = 1'b0; e_ack[p] = 1'b0; e_err[p] = 1'b0;
        end
        e_creq = 1'b0;
    endtask

    function automatic int pick_delay();
        int r;
        r = int'($urandom_range(9));
        if (r <= 5) return int'($urandom_range(4, 1));
        else if (r == 6) return TMO;
        else if (r == 7) return TMO - 1;
        else if (r == 8) return NEVER;
        else return int'($urandom_range(TMO, 1));
    endfunction

    // Set requester and controller inputs for the coming edge
    task automatic drive();
        for (int p = 0; p < 2; p++) begin
            if (!pend_v[p] && int'($urandom_range(99)) < gen_pct) begin
                pend_v[p]    = 1'b1;
                pend_rw[p]   = 1'($urandom_range(1));
                pend_addr[p] = 16'($urandom);
                pend_wd[p]   = 8'($urandom);
            end
        end
        p0_req = pend_v[0]; p0_rw = pend_rw[0]; p0_addr = pend_addr[0]; p0_wdata = pend_wd[0];
        p1_req = pend_v[1]; p1_rw = pend_rw[1]; p1_addr = pend_addr[1]; p1_wdata = pend_wd[1];
        ctl_rdata = (rdata_fix >= 0) ? 8'(rdata_fix) : 8'($urandom);
        if (busy_m) ctl_done = (edge_n + 1 == done_edge);
        else        ctl_done = (int'($urandom_range(99)) < stray_pct);
    endtask

    // Predict the effect of the coming edge from the access-level rules
    task automatic predict();
        int w;
        for (int p = 0; p < 2; p++) begin
            e_gnt[p] = 1'b0; e_ack[p] = 1'b0; e_err[p] = 1'b0;
        end
        e_creq = 1'b0;
        edge_n++;
        if (!busy_m) begin
            if (pend_v[0] || pend_v[1]) begin
                w = (pend_v[0] && pend_v[1]) ? ptr_m : (pend_v[1] ? 1 : 0);
                e_gnt[w] = 1'b1; e_creq = 1'b1;
                c_rw = pend_rw[w]; c_addr = pend_addr[w]; c_wdata = pend_wd[w];
                busy_m = 1'b1; owner_m = w; ptr_m = 1 - w; grant_edge = edge_n;
                pend_v[w] = 1'b0;
                done_edge = edge_n + ((forced_d >= 0) ? forced_d : pick_delay());
            end
        end else begin
            if (ctl_done) begin
                e_ack[owner_m] = 1'b1;
                if (c_rw) rdata_m[owner_m] = ctl_rdata;
                busy_m = 1'b0;
            end else if (edge_n == grant_edge + TMO) begin
                e_ack[owner_m] = 1'b1; e_err[owner_m] = 1'b1;
                rdata_m[owner_m] = '0;
                busy_m = 1'b0;
            end
        end
    endtask

    task automatic compare_all();
        chk("p0_gnt", p0_gnt, e_gnt[0]);   chk("p1_gnt", p1_gnt, e_gnt[1]);
        chk("p0_ack", p0_ack, e_ack[0]);   chk("p1_ack", p1_ack, e_ack[1]);
        chk("p0_err", p0_err, e_err[0]);   chk("p1_err", p1_err, e_err[1]);
        chk("p0_rdata", p0_rdata, rdata_m[0]); chk("p1_rdata", p1_rdata, rdata_m[1]);
        chk("ctl_req", ctl_req, e_creq);   chk("ctl_rw", ctl_rw, c_rw);
        chk("ctl_addr", ctl_addr, c_addr); chk("ctl_wdata", ctl_wdata, c_wdata);
        if (p0_gnt) dut_log.push_back(0);
        if (p1_gnt) dut_log.push_back(1);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            drive();
            predict();
            @(posedge clk);
            @(negedge clk);
            compare_all();
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_gnt"},  {p1_gnt, p0_gnt}, 2'b00);
        chk({tag, "_ack"},  {p1_ack, p0_ack}, 2'b00);
        chk({tag, "_err"},  {p1_err, p0_err}, 2'b00);
        chk({tag, "_creq"}, ctl_req, 1'b0);
        chk({tag, "_rw"},   ctl_rw, 1'b1);
        chk({tag, "_addr"}, ctl_addr, 16'h0000);
        chk({tag, "_wd"},   ctl_wdata, 8'h00);
        chk({tag, "_rd"},   {p1_rdata, p0_rdata}, 16'h0000);
    endtask

    task automatic set_cmd(input int p, input bit rw, input logic [15:0] a, input logic [7:0] d);
        pend_v[p] = 1'b1; pend_rw[p] = rw; pend_addr[p] = a; pend_wd[p] = d;
    endtask

    // Hold reset for two edges, release at a falling edge
    task automatic full_reset();
        reset = 1'b1;
        model_reset();
        @(posedge clk); @(posedge clk); @(negedge clk);
        check_reset_values("rst");
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; edge_n = 0;
        p0_req = 1'b0; p0_rw = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_req = 1'b0; p1_rw = 1'b0; p1_addr = '0; p1_wdata = '0;
        ctl_done = 1'b0; ctl_rdata = '0;
        for (int p = 0; p < 2; p++) pend_v[p] = 1'b0;
        gen_pct = 0; stray_pct = 0; forced_d = 1; rdata_fix = -1;
        full_reset();

        // Single write from p0, done sampled two edges after the grant
        set_cmd(0, 1'b0, 16'h00AA, 8'h55); forced_d = 2;
        step(1);
        chk("wr_ctl_addr", ctl_addr, 16'h00AA);
        chk("wr_ctl_wdata", ctl_wdata, 8'h55);
        step(4);

        // Single read from p1 returning A5
        set_cmd(1, 1'b1, 16'h00BB, 8'h00); forced_d = 1; rdata_fix = 8'hA5;
        step(2);
        chk("rd_p1_ack", p1_ack, 1'b1);
        chk("rd_p1_rdata", p1_rdata, 8'hA5);
        step(2);
        rdata_fix = -1;

        // Timeout: p0 read never completed, then a normal access
        set_cmd(0, 1'b1, 16'h1234, 8'h00); forced_d = NEVER;
        step(TMO + 2);
        set_cmd(1, 1'b0, 16'h4321, 8'h77); forced_d = 1;
        step(4);

        // Boundary: done on the final timeout edge still completes cleanly
        set_cmd(0, 1'b1, 16'h0F0F, 8'h00); forced_d = TMO; rdata_fix = 8'h3C;
        step(TMO + 1);
        chk("bnd_p0_rdata", p0_rdata, 8'h3C);
        rdata_fix = -1;

        // Stray controller done while idle
        stray_pct = 100;
        step(6);
        stray_pct = 0;

        // Contention from the first edge after reset release
        reset = 1'b1;
        model_reset();
        @(posedge clk); @(negedge clk);
        set_cmd(0, 1'b0, 16'h0001, 8'h11); set_cmd(1, 1'b0, 16'h0002, 8'h22);
        reset = 1'b0;
        dut_log.delete();
        gen_pct = 100; forced_d = 1;
        step(14);
        gen_pct = 0;
        chk("cont_ngrants", (dut_log.size() >= 4) ? 1 : 0, 1);
        for (int i = 0; i < 4 && i < dut_log.size(); i++)
            chk($sformatf("cont_order%0d", i), dut_log[i], i % 2);
        step(6);
        for (int p = 0; p < 2; p++) pend_v[p] = 1'b0;
        step(TMO + 2);

        // Reset in the middle of WAIT abandons the access
        set_cmd(1, 1'b0, 16'hBEEF, 8'h99); forced_d = NEVER;
        step(2);
        reset = 1'b1;
        #1;
        check_reset_values("midrst");
        model_reset();
        @(posedge clk); @(negedge clk);
        set_cmd(0, 1'b1, 16'h0A0A, 8'h00); set_cmd(1, 1'b1, 16'h0B0B, 8'h00);
        reset = 1'b0;
        forced_d = 2;
        step(1);
        chk("midrst_p0_first", p0_gnt, 1'b1);
        step(TMO + 4);

        // Randomized traffic
        gen_pct = 35; stray_pct = 10; forced_d = -1;
        step(3000);
        gen_pct = 0; stray_pct = 0;
        step(TMO + 4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
